// File: rtl/delta_sigma_fifo_pkg.sv
// delta_sigma_fifo_pkg
// Shared definitions for the delta-sigma packing/unpacking FIFOs:
//   - default sample width, word width and word storage depth
//   - log2 helper used to size pointers and counters
//   - derivation of RATIO (samples per word) and of the counter widths
package delta_sigma_fifo_pkg;

  localparam int DEF_WIDTH_IN  = 8;
  localparam int DEF_WIDTH_OUT = 24;
  localparam int DEF_DEPTH     = 128;

  // Ceiling log2; log2_ceil(1) = 0.
  function automatic int log2_ceil(input int value);
    int result;
    result = 0;
    while ((32'sd1 <<< result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

  function automatic int ratio_of(input int width_in, input int width_out);
    return width_out / width_in;
  endfunction

  // fifo_count has to represent DEPTH itself, hence DEPTH+1 states.
  function automatic int count_width(input int depth);
    return log2_ceil(depth + 1);
  endfunction

  // byte_count runs 0..RATIO-1.
  function automatic int byte_count_width(input int ratio);
    return log2_ceil(ratio);
  endfunction

  // Memory address width; kept at least one bit wide.
  function automatic int addr_width(input int depth);
    return (depth > 1) ? log2_ceil(depth) : 1;
  endfunction

endpackage

// File: rtl/delta_sigma_pack_fifo_if.sv
// delta_sigma_pack_fifo_if
// Handshake/data bundle of the byte-to-word packing FIFO.
//   master : producer/consumer side (drives write_en, datain, flush, read_en)
//   slave  : the FIFO (drives dataout, fifo_count, byte_count, empty, full)
interface delta_sigma_pack_fifo_if
  import delta_sigma_fifo_pkg::*;
#(
  parameter int WIDTH_IN  = DEF_WIDTH_IN,
  parameter int WIDTH_OUT = DEF_WIDTH_OUT,
  parameter int DEPTH     = DEF_DEPTH
);

  localparam int RATIO = ratio_of(WIDTH_IN, WIDTH_OUT);
  localparam int CNT_W = count_width(DEPTH);
  localparam int BC_W  = byte_count_width(RATIO);

  logic                 write_en;
  logic [WIDTH_IN-1:0]  datain;
  logic                 flush;
  logic                 read_en;
  logic [WIDTH_OUT-1:0] dataout;
  logic [CNT_W-1:0]     fifo_count;
  logic [BC_W-1:0]      byte_count;
  logic                 empty;
  logic                 full;

  modport master (
    output write_en, datain, flush, read_en,
    input  dataout, fifo_count, byte_count, empty, full
  );

  modport slave (
    input  write_en, datain, flush, read_en,
    output dataout, fifo_count, byte_count, empty, full
  );

endinterface

// File: rtl/delta_sigma_byte_packer.sv
// delta_sigma_byte_packer
// Gathers RATIO samples into one word, first sample in the MSBs, and raises
// commit for the cycle in which the word must be written to storage.
//   clk, reset_n      : clock, synchronous active-low reset
//   write_valid       : accepted sample on datain this cycle
//   flush             : request to pad and commit a partial word
//   storage_has_room  : storage is below DEPTH words
//   datain            : sample
//   word              : word to store (valid while commit is high)
//   commit            : write word to storage this cycle
//   byte_count        : samples currently held (0..RATIO-1)
module delta_sigma_byte_packer
  import delta_sigma_fifo_pkg::*;
#(
  parameter int  WIDTH_IN  = DEF_WIDTH_IN,
  parameter int  WIDTH_OUT = DEF_WIDTH_OUT,
  localparam int RATIO     = ratio_of(WIDTH_IN, WIDTH_OUT),
  localparam int BC_W      = byte_count_width(RATIO)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 write_valid,
  input  logic                 flush,
  input  logic                 storage_has_room,
  input  logic [WIDTH_IN-1:0]  datain,
  output logic [WIDTH_OUT-1:0] word,
  output logic                 commit,
  output logic [BC_W-1:0]      byte_count
);

  localparam logic [BC_W-1:0] LAST_SLOT = BC_W'(RATIO - 1);

  logic [WIDTH_OUT-1:0] asm_q, asm_d;
  logic [BC_W-1:0]      byte_count_q, byte_count_d;
  logic [WIDTH_OUT-1:0] placed_s;
  logic [WIDTH_OUT-1:0] merged_s;
  logic                 write_commit_s;
  logic                 flush_commit_s;
  logic                 commit_s;

  // Position the incoming sample in the slot selected by byte_count.
  always_comb begin
    placed_s = '0;
    for (int k = 0; k < RATIO; k++) begin
      placed_s[WIDTH_OUT-1-k*WIDTH_IN -: WIDTH_IN] =
        (byte_count_q == BC_W'(k)) ? datain : {WIDTH_IN{1'b0}};
    end
  end

  // Commit decision and next assembler state. Slots not yet written are
  // always zero, so a flushed word is zero-padded without extra logic.
  always_comb begin
    write_commit_s = write_valid && (byte_count_q == LAST_SLOT);
    // A write that completes the word wins; the flush is dropped for the caller to retry.
    flush_commit_s = flush && (byte_count_q != '0) && storage_has_room && !write_commit_s;
    commit_s       = write_commit_s || flush_commit_s;
    merged_s       = write_valid ? (asm_q | placed_s) : asm_q;

    if (commit_s) begin
      asm_d        = '0;
      byte_count_d = '0;
    end else if (write_valid) begin
      asm_d        = merged_s;
      byte_count_d = byte_count_q + BC_W'(1);
    end else begin
      asm_d        = asm_q;
      byte_count_d = byte_count_q;
    end
  end

  // Assembler and sample counter registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      asm_q        <= '0;
      byte_count_q <= '0;
    end else begin
      asm_q        <= asm_d;
      byte_count_q <= byte_count_d;
    end
  end

  assign word       = merged_s;
  assign commit     = commit_s;
  assign byte_count = byte_count_q;

endmodule

// File: rtl/delta_sigma_pack_fifo.sv
// delta_sigma_pack_fifo
// Byte-to-word packing FIFO with first-word-fall-through output and an
// end-of-line flush that zero-pads a partial word.
//   clk     : clock, all state changes on the rising edge
//   reset_n : synchronous active-low reset (memory contents are kept)
//   bus     : slave side of delta_sigma_pack_fifo_if
//             in : write_en, datain, flush, read_en
//             out: dataout (head word), fifo_count, byte_count, empty, full
module delta_sigma_pack_fifo
  import delta_sigma_fifo_pkg::*;
#(
  parameter int  WIDTH_IN  = DEF_WIDTH_IN,
  parameter int  WIDTH_OUT = DEF_WIDTH_OUT,
  parameter int  DEPTH     = DEF_DEPTH,
  localparam int RATIO     = ratio_of(WIDTH_IN, WIDTH_OUT),
  localparam int CNT_W     = count_width(DEPTH),
  localparam int BC_W      = byte_count_width(RATIO),
  localparam int AW        = addr_width(DEPTH)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  delta_sigma_pack_fifo_if.slave  bus
);

  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
  localparam logic [BC_W-1:0]  LAST_SLOT = BC_W'(RATIO - 1);

  logic [WIDTH_OUT-1:0] mem_q [DEPTH];
  logic [AW-1:0]        add_wr_q, add_wr_d;
  logic [AW-1:0]        add_rd_q, add_rd_d;
  logic [CNT_W-1:0]     fifo_count_q, fifo_count_d;

  logic                 empty_s;
  logic                 full_s;
  logic                 room_s;
  logic                 write_valid_s;
  logic                 read_valid_s;
  logic                 commit_s;
  logic [WIDTH_OUT-1:0] word_s;
  logic [BC_W-1:0]      byte_count_s;

  // Flags are decoded straight from registered state, no extra lag.
  always_comb begin
    empty_s       = (fifo_count_q == '0);
    room_s        = (fifo_count_q != DEPTH_CNT);
    // Full only when no further sample could be accepted without a commit.
    full_s        = !room_s && (byte_count_s == LAST_SLOT);
    write_valid_s = bus.write_en && !full_s;
    read_valid_s  = bus.read_en && !empty_s;
  end

  delta_sigma_byte_packer #(
    .WIDTH_IN  (WIDTH_IN),
    .WIDTH_OUT (WIDTH_OUT)
  ) u_packer (
    .clk              (clk),
    .reset_n          (reset_n),
    .write_valid      (write_valid_s),
    .flush            (bus.flush),
    .storage_has_room (room_s),
    .datain           (bus.datain),
    .word             (word_s),
    .commit           (commit_s),
    .byte_count       (byte_count_s)
  );

  // Pointer and occupancy next state; DEPTH is a power of two so the
  // pointers wrap by natural overflow.
  always_comb begin
    add_wr_d = commit_s ? (add_wr_q + AW'(1)) : add_wr_q;
    add_rd_d = read_valid_s ? (add_rd_q + AW'(1)) : add_rd_q;
    case ({commit_s, read_valid_s})
      2'b10:   fifo_count_d = fifo_count_q + CNT_W'(1);
      2'b01:   fifo_count_d = fifo_count_q - CNT_W'(1);
      default: fifo_count_d = fifo_count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      add_wr_q     <= '0;
      add_rd_q     <= '0;
      fifo_count_q <= '0;
    end else begin
      add_wr_q     <= add_wr_d;
      add_rd_q     <= add_rd_d;
      fifo_count_q <= fifo_count_d;
    end
  end

  // Word storage: write port only, contents deliberately not reset.
  always_ff @(posedge clk) begin
    if (commit_s) begin
      mem_q[add_wr_q] <= word_s;
    end
  end

  assign bus.dataout    = mem_q[add_rd_q];
  assign bus.fifo_count = fifo_count_q;
  assign bus.byte_count = byte_count_s;
  assign bus.empty      = empty_s;
  assign bus.full       = full_s;

endmodule

// File: tb/tb_delta_sigma_pack_fifo.sv
// tb_delta_sigma_pack_fifo
// Directed bench for delta_sigma_pack_fifo with a queue-based reference
// model checked on every negative clock edge plus literal expectations.
module tb_delta_sigma_pack_fifo;

  localparam int WI    = 8;
  localparam int WO    = 24;
  localparam int DEPTH = 128;
  localparam int RATIO = 3;

  logic clk = 1'b0;
  logic reset_n;

  always #5 clk = ~clk;

  delta_sigma_pack_fifo_if #(.WIDTH_IN(WI), .WIDTH_OUT(WO), .DEPTH(DEPTH)) bus ();

  delta_sigma_pack_fifo #(.WIDTH_IN(WI), .WIDTH_OUT(WO), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: stored words and bytes of the partial word.
  logic [WO-1:0] mq[$];
  logic [WI-1:0] mp[$];
  bit            model_live = 1'b0;

  function automatic logic [WO-1:0] pack_word(input logic [WI-1:0] b[$]);
    logic [WO-1:0] w;
    w = '0;
    for (int k = 0; k < RATIO; k++) begin
      w = (w << WI) | ((k < b.size()) ? WO'(b[k]) : WO'(0));
    end
    return w;
  endfunction

  always @(posedge clk) begin : model
    bit            mfull;
    bit            wv;
    bit            rv;
    int            n;
    logic [WI-1:0] p[$];
    if (!reset_n) begin
      mq.delete();
      mp.delete();
    end else begin
      n     = mq.size();
      mfull = (n == DEPTH) && (mp.size() == RATIO - 1);
      wv    = bus.write_en && !mfull;
      rv    = bus.read_en && (n != 0);
      p     = mp;
      if (wv) p.push_back(bus.datain);
      if (rv) void'(mq.pop_front());
      if (p.size() == RATIO) begin
        mq.push_back(pack_word(p));
        p.delete();
      end else if (bus.flush && mp.size() != 0 && n != DEPTH) begin
        mq.push_back(pack_word(p));
        p.delete();
      end
      mp = p;
    end
    model_live = 1'b1;
  end

  always @(negedge clk) begin
    if (model_live) begin
      chk("m_empty", 32'(bus.empty), 32'(mq.size() == 0));
      chk("m_full", 32'(bus.full), 32'((mq.size() == DEPTH) && (mp.size() == RATIO - 1)));
      chk("m_fifo_count", 32'(bus.fifo_count), 32'(mq.size()));
      chk("m_byte_count", 32'(bus.byte_count), 32'(mp.size()));
      if (mq.size() != 0) chk("m_dataout", 32'(bus.dataout), 32'(mq[0]));
    end
  end

  task automatic step(input logic we, input logic [WI-1:0] d, input logic fl, input logic re);
    bus.write_en = we;
    bus.datain   = d;
    bus.flush    = fl;
    bus.read_en  = re;
    @(posedge clk);
    #1;
  endtask

  initial begin : stim
    int widx;
    int b;
    reset_n = 1'b0;
    step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("rst_empty", 32'(bus.empty), 32'd1);
    chk("rst_full", 32'(bus.full), 32'd0);
    chk("rst_fifo_count", 32'(bus.fifo_count), 32'd0);
    chk("rst_byte_count", 32'(bus.byte_count), 32'd0);
    reset_n = 1'b1;

    // Three samples make one word.
    step(1'b1, 8'h11, 1'b0, 1'b0);
    chk("w1_byte_count", 32'(bus.byte_count), 32'd1);
    step(1'b1, 8'h22, 1'b0, 1'b0);
    step(1'b1, 8'h33, 1'b0, 1'b0);
    chk("w3_dataout", 32'(bus.dataout), 32'h112233);
    chk("w3_fifo_count", 32'(bus.fifo_count), 32'd1);
    chk("w3_empty", 32'(bus.empty), 32'd0);
    chk("w3_byte_count", 32'(bus.byte_count), 32'd0);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("rd_empty", 32'(bus.empty), 32'd1);

    // Flush of a two-sample partial word, then a flush with nothing held.
    step(1'b1, 8'hAA, 1'b0, 1'b0);
    step(1'b1, 8'hBB, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("fl_dataout", 32'(bus.dataout), 32'hAABB00);
    chk("fl_fifo_count", 32'(bus.fifo_count), 32'd1);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("fl0_fifo_count", 32'(bus.fifo_count), 32'd1);
    chk("fl0_byte_count", 32'(bus.byte_count), 32'd0);
    step(1'b0, 8'h00, 1'b0, 1'b1);

    // Write together with flush at byte_count 1.
    step(1'b1, 8'hCC, 1'b0, 1'b0);
    step(1'b1, 8'hDD, 1'b1, 1'b0);
    chk("wfl_dataout", 32'(bus.dataout), 32'hCCDD00);
    chk("wfl_fifo_count", 32'(bus.fifo_count), 32'd1);
    chk("wfl_byte_count", 32'(bus.byte_count), 32'd0);
    step(1'b0, 8'h00, 1'b0, 1'b1);

    // Reset in the middle of a word discards the partial.
    step(1'b1, 8'h55, 1'b0, 1'b0);
    step(1'b1, 8'h66, 1'b0, 1'b0);
    reset_n = 1'b0;
    step(1'b0, 8'h00, 1'b0, 1'b0);
    reset_n = 1'b1;
    chk("mrst_byte_count", 32'(bus.byte_count), 32'd0);
    step(1'b1, 8'h01, 1'b0, 1'b0);
    step(1'b1, 8'h02, 1'b0, 1'b0);
    step(1'b1, 8'h03, 1'b0, 1'b0);
    chk("mrst_dataout", 32'(bus.dataout), 32'h010203);
    chk("mrst_fifo_count", 32'(bus.fifo_count), 32'd1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("mrst_empty", 32'(bus.empty), 32'd1);

    // Fill DEPTH words plus RATIO-1 samples.
    for (int i = 0; i < DEPTH * RATIO + 2; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
    chk("fill_full", 32'(bus.full), 32'd1);
    chk("fill_fifo_count", 32'(bus.fifo_count), 32'd128);
    chk("fill_byte_count", 32'(bus.byte_count), 32'd2);
    chk("fill_head", 32'(bus.dataout), 32'h000102);
    step(1'b1, 8'hEE, 1'b0, 1'b0);
    chk("full_wr_ignored", 32'(bus.byte_count), 32'd2);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("full_fl_ignored", 32'(bus.fifo_count), 32'd128);
    step(1'b1, 8'h77, 1'b0, 1'b1);
    chk("full_rw_count", 32'(bus.fifo_count), 32'd127);
    chk("full_rw_byte_count", 32'(bus.byte_count), 32'd2);
    chk("full_rw_head", 32'(bus.dataout), 32'h030405);
    step(1'b1, 8'h77, 1'b0, 1'b0);
    chk("refill_count", 32'(bus.fifo_count), 32'd128);
    chk("refill_byte_count", 32'(bus.byte_count), 32'd0);
    chk("refill_full", 32'(bus.full), 32'd0);
    for (int n = 0; n < 2 * DEPTH && !bus.empty; n++) step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("drain_empty", 32'(bus.empty), 32'd1);

    // Streaming with read_en held high, across several pointer wraps.
    widx = 0;
    for (int i = 0; i < 1200; i++) begin
      step(1'b1, 8'(i), 1'b0, 1'b1);
      if (!bus.empty) begin
        b = 3 * widx;
        chk("stream_word", 32'(bus.dataout), {8'h00, 8'(b), 8'(b + 1), 8'(b + 2)});
        widx++;
      end
    end
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("stream_words", 32'(widx), 32'd400);
    chk("stream_empty", 32'(bus.empty), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
